word_serializer: RTL



---
 rtl/word_serializer_pkg.sv | 17 +
 rtl/word_serializer_mux.sv | 25 ++
 rtl/word_serializer.sv | 71 +++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared helpers for the word serializer slice
package word_serializer_pkg;

  // Ceiling log2, used to size beat counters and mux selects.
  // Returns at least 1 so a two-word vector still gets a 1-bit select.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/word_serializer_mux.sv
// rtl/word_serializer_mux.sv - word-select mux over a packed vector
module word_serializer_mux
  import word_serializer_pkg::*;
#(
  parameter int NUM_INPUT = 4,
  parameter int BIT_WIDTH = 8
) (
  input  logic [NUM_INPUT*BIT_WIDTH-1:0] input_data,
  input  logic [clog2(NUM_INPUT)-1:0]    select,
  output logic [BIT_WIDTH-1:0]           output_data
);

  localparam int SEL_W = clog2(NUM_INPUT);

  // Pick word[select]; out-of-range selects (non-power-of-2 sizes) yield zero.
  always_comb begin
    output_data = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      if (select == SEL_W'(i)) begin
        output_data = input_data[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel vector in, one word per beat out
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int NUM_INPUT = 4,
  parameter int BIT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [NUM_INPUT*BIT_WIDTH-1:0] in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [BIT_WIDTH-1:0]           out_data,
  output logic                           out_last,
  input  logic                           out_ready
);

  localparam int SEL_W = clog2(NUM_INPUT);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_INPUT - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  logic                           state_q;
  logic [SEL_W-1:0]               sel_q;
  logic [NUM_INPUT*BIT_WIDTH-1:0] vec_q;

  logic sel_is_last;
  logic beat;
  logic load;

  // The final beat of a vector frees the register, so a new vector may load
  // in the same cycle and the output stream keeps one word per clock.
  assign sel_is_last = (sel_q == LAST_SEL);
  assign out_valid   = (state_q == ST_SEND);
  assign out_last    = out_valid & sel_is_last;
  assign in_ready    = (state_q == ST_IDLE) | (out_valid & sel_is_last & out_ready);
  assign beat        = out_valid & out_ready;
  assign load        = in_valid & in_ready;

  // FSM, beat counter and vector register; the counter wraps explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      vec_q   <= '0;
    end else if (load) begin
      vec_q   <= in_data;
      sel_q   <= '0;
      state_q <= ST_SEND;
    end else if (beat) begin
      if (sel_is_last) begin
        sel_q   <= '0;
        state_q <= ST_IDLE;
      end else begin
        sel_q   <= sel_q + SEL_W'(1);
      end
    end
  end

  word_serializer_mux #(
    .NUM_INPUT (NUM_INPUT),
    .BIT_WIDTH (BIT_WIDTH)
  ) u_mux (
    .input_data  (vec_q),
    .select      (sel_q),
    .output_data (out_data)
  );

endmodule
